// File: rtl/mini_cpu_pkg.sv
// Shared mini CPU decode-stage definitions: register address width, address type
// and the hard-wired zero register.
package mini_cpu_pkg;

   localparam int ADDR_W = 5;

   typedef logic [ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on
// writeback. Register 0 never becomes pending.
module reg_scoreboard #(
   parameter int ADDR_W = mini_cpu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              pend
);
   import mini_cpu_pkg::*;

   localparam int NREG = 2 ** ADDR_W;

   logic [NREG-1:0] pend_r;
   logic [NREG-1:0] pend_nxt_s;

   // Next pending state: an issue beats a writeback to the same register.
   always_comb begin
      pend_nxt_s = pend_r;
      for (int i = 0; i < NREG; i++) begin
         if (i == 0) begin
            pend_nxt_s[i] = 1'b0;
         end else if (iss_en && (iss_addr == ADDR_W'(i))) begin
            pend_nxt_s[i] = 1'b1;
         end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
            pend_nxt_s[i] = 1'b0;
         end else begin
            pend_nxt_s[i] = pend_r[i];
         end
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r <= {NREG{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
      end
   end

   // Register 0 reads as never pending regardless of the array contents.
   assign pend = (lookup_addr == ADDR_W'(REG_ZERO)) ? 1'b0 : pend_r[lookup_addr];

endmodule

// File: rtl/read_port_sel.sv
// Register-file read-port address selector with pending-write stall and a
// one-entry valid/ready output stage. Define READPORT_BYPASS_EN to let a
// same-cycle writeback release the stall.
module read_port_sel #(
   parameter int ADDR_W = mini_cpu_pkg::ADDR_W,
   parameter int NSRC   = 4,
   parameter int SEL_W  = $clog2(NSRC)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NSRC*ADDR_W-1:0] src_addr,
   input  logic [SEL_W-1:0]       sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [ADDR_W-1:0]      out_addr,
   output logic                   out_valid,
   input  logic                   out_ready,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_addr,
   input  logic                   wb_en,
   input  logic [ADDR_W-1:0]      wb_addr,
   output logic                   hazard
);
   import mini_cpu_pkg::*;

   localparam int NSLOT = 2 ** SEL_W;

   logic [ADDR_W-1:0] fld_s [NSLOT];
   logic [ADDR_W-1:0] cand_s;
   logic              pend_s;
   logic              hazard_s;
   logic              accept_s;
   logic [ADDR_W-1:0] out_addr_r;
   logic              out_valid_r;

   // Unused select codes map to a zero field so the mux is a plain index.
   for (genvar i = 0; i < NSLOT; i++) begin : g_fld
      if (i < NSRC) begin : g_real
         assign fld_s[i] = src_addr[i*ADDR_W +: ADDR_W];
      end else begin : g_zero
         assign fld_s[i] = ADDR_W'(REG_ZERO);
      end
   end

   assign cand_s = fld_s[sel];

   reg_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .iss_en      (iss_en),
      .iss_addr    (iss_addr),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .lookup_addr (cand_s),
      .pend        (pend_s)
   );

`ifdef READPORT_BYPASS_EN
   assign hazard_s = in_valid & pend_s & ~(wb_en & (wb_addr == cand_s));
`else
   assign hazard_s = in_valid & pend_s;
`endif

   assign accept_s = in_valid & ~hazard_s & (~out_valid_r | out_ready);

   // Output stage: load on accept, drain when consumed, hold under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_addr_r  <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_addr_r  <= cand_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
         out_addr_r  <= out_addr_r;
      end else begin
         out_valid_r <= out_valid_r;
         out_addr_r  <= out_addr_r;
      end
   end

   assign hazard    = hazard_s;
   assign in_ready  = ~hazard_s & (~out_valid_r | out_ready);
   assign out_addr  = out_addr_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_read_port_sel.sv
// Self-checking bench for read_port_sel: directed scenarios plus random traffic
// against a pending-set / output-slot reference model.
module tb_read_port_sel;

   logic        clk;
   logic        rst;
   logic [19:0] src_addr;
   logic [1:0]  sel;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  out_addr;
   logic        out_valid;
   logic        out_ready;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic        hazard;

   int n_cmp;
   int n_err;

   // reference model state
   bit pend_m [32];
   bit ov_m;
   int oa_m;

   read_port_sel dut (
      .clk       (clk),
      .rst       (rst),
      .src_addr  (src_addr),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .hazard    (hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs after negedge, check against model, clock, update model.
   task automatic step(input bit iv, input bit [1:0] s, input bit [19:0] src, input bit orr,
                       input bit ie, input bit [4:0] ia, input bit we, input bit [4:0] wa,
                       input bit r);
      int  cand;
      bit  hz;
      bit  rdy;
      in_valid  = iv;
      sel       = s;
      src_addr  = src;
      out_ready = orr;
      iss_en    = ie;
      iss_addr  = ia;
      wb_en     = we;
      wb_addr   = wa;
      rst       = r;
      #1;
      cand = (src >> (5 * int'(s))) & 32'd31;
      hz   = iv && pend_m[cand];
`ifdef READPORT_BYPASS_EN
      if (we && (int'(wa) == cand)) hz = 1'b0;
`endif
      rdy = !hz && (!ov_m || orr);
      chk("hazard", 32'(hazard), 32'(hz));
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      chk("out_addr", 32'(out_addr), oa_m);
      @(posedge clk);
      if (r) begin
         ov_m = 1'b0;
         oa_m = 0;
         foreach (pend_m[k]) pend_m[k] = 1'b0;
      end else begin
         if (iv && rdy) begin
            ov_m = 1'b1;
            oa_m = cand;
         end else if (ov_m && orr) begin
            ov_m = 1'b0;
         end
         if (we) pend_m[wa] = 1'b0;
         if (ie && ia != 5'd0) pend_m[ia] = 1'b1;
      end
      @(negedge clk);
   endtask

   // idle cycle with optional out_ready
   task automatic idle(input bit orr);
      step(1'b0, 2'd0, 20'd0, orr, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   localparam bit [19:0] SRC_A = {5'd12, 5'd9, 5'd7, 5'd3};
   localparam bit [19:0] SRC_Z = {5'd12, 5'd9, 5'd7, 5'd0};
   localparam bit [19:0] SRC_5 = {5'd12, 5'd9, 5'd7, 5'd5};

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; in_valid = 1'b0; sel = 2'd0; src_addr = 20'd0; out_ready = 1'b0;
      iss_en = 1'b0; iss_addr = 5'd0; wb_en = 1'b0; wb_addr = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      foreach (pend_m[k]) pend_m[k] = 1'b0;
      ov_m = 1'b0;
      oa_m = 0;

      // reset values, then in_ready with a request and nothing pending
      idle(1'b1);
      step(1'b1, 2'd1, SRC_A, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t1_addr", 32'(out_addr), 32'd7);
      chk("t1_valid", 32'(out_valid), 32'd1);
      idle(1'b1);

      // stall on pending register 9 until its writeback
      step(1'b0, 2'd0, SRC_A, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
      step(1'b1, 2'd2, SRC_A, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t2_stall", 32'(out_valid), 32'd0);
      step(1'b1, 2'd2, SRC_A, 1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
      step(1'b1, 2'd2, SRC_A, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t2_addr", 32'(out_addr), 32'd9);
      idle(1'b1);

      // issue to register 0 is ignored
      step(1'b0, 2'd0, SRC_Z, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 2'd0, SRC_Z, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t3_zero", 32'(out_valid), 32'd1);
      idle(1'b1);

      // backpressure holds 3 while a request for 12 waits
      step(1'b1, 2'd0, SRC_A, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 2'd3, SRC_A, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 2'd3, SRC_A, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t4_hold", 32'(out_addr), 32'd3);
      step(1'b1, 2'd3, SRC_A, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t4_next", 32'(out_addr), 32'd12);
      idle(1'b1);

      // simultaneous issue and writeback to 5: set wins, later request stalls
      step(1'b0, 2'd0, SRC_5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0);
      step(1'b1, 2'd0, SRC_5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t5_stall", 32'(out_valid), 32'd0);
      step(1'b0, 2'd0, SRC_5, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);

      // reset with output valid and two registers pending
      step(1'b0, 2'd0, SRC_A, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
      step(1'b1, 2'd3, SRC_A, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
      step(1'b0, 2'd0, SRC_A, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      chk("t6_valid", 32'(out_valid), 32'd0);
      step(1'b1, 2'd1, SRC_A, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 2'd2, SRC_A, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

      // random traffic over a small address window to force collisions
      for (int n = 0; n < 600; n++) begin
         bit [19:0] src;
         src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         step(1'($urandom_range(0, 3) != 0), 2'($urandom), src, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
